// File: rtl/cf_merge_arbiter.sv
// Two-input round-robin merge arbiter that joins two 4-phase handshake streams onto one
// shared downstream channel, with a count of completed transfers for each requester.
module cf_merge_arbiter #(
    parameter int DW = 32,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          MR_n,
    input  logic          Send_in0,
    input  logic          Send_in1,
    input  logic [DW-1:0] Data_in0,
    input  logic [DW-1:0] Data_in1,
    output logic          Ack_out0,
    output logic          Ack_out1,
    output logic          Send_out,
    output logic [DW-1:0] Data_out,
    input  logic          Ack_in,
    output logic          Gnt,
    output logic          Busy,
    output logic [CW-1:0] Cnt0,
    output logic [CW-1:0] Cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CntOne = CW'(1);

    logic [1:0]    send0Sync_q;
    logic [1:0]    send1Sync_q;
    logic [1:0]    ackSync_q;
    state_t        state_q;
    logic          sendOut_q;
    logic          ackOut0_q;
    logic          ackOut1_q;
    logic [DW-1:0] dataOut_q;
    logic          gnt_q;
    logic [CW-1:0] cnt0_q;
    logic [CW-1:0] cnt1_q;

    logic sendS0;
    logic sendS1;
    logic ackS;
    logic sendSGnt;
    logic grantValid_d;
    logic grantIdx_d;

    // Handshake inputs come from other timing domains; only the second flop is ever used.
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            send0Sync_q <= '0;
            send1Sync_q <= '0;
            ackSync_q   <= '0;
        end else begin
            send0Sync_q <= {send0Sync_q[0], Send_in0};
            send1Sync_q <= {send1Sync_q[0], Send_in1};
            ackSync_q   <= {ackSync_q[0], Ack_in};
        end
    end

    assign sendS0   = send0Sync_q[1];
    assign sendS1   = send1Sync_q[1];
    assign ackS     = ackSync_q[1];
    assign sendSGnt = gnt_q ? sendS1 : sendS0;

    // On a tie the requester that did not win last time takes the bus.
    always_comb begin
        grantValid_d = 1'b0;
        grantIdx_d   = gnt_q;
        if (sendS0 && sendS1) begin
            grantValid_d = 1'b1;
            grantIdx_d   = ~gnt_q;
        end else if (sendS0) begin
            grantValid_d = 1'b1;
            grantIdx_d   = 1'b0;
        end else if (sendS1) begin
            grantValid_d = 1'b1;
            grantIdx_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            state_q   <= IDLE;
            sendOut_q <= 1'b0;
            ackOut0_q <= 1'b0;
            ackOut1_q <= 1'b0;
            dataOut_q <= '0;
            gnt_q     <= 1'b1;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grantValid_d) begin
                        gnt_q     <= grantIdx_d;
                        dataOut_q <= grantIdx_d ? Data_in1 : Data_in0;
                        sendOut_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (ackS) begin
                        sendOut_q <= 1'b0;
                        if (gnt_q) ackOut1_q <= 1'b1;
                        else       ackOut0_q <= 1'b1;
                        state_q   <= REL;
                    end
                end
                REL: begin
                    // Both sides must have returned to zero before the transfer counts as done.
                    if (!ackS && !sendSGnt) begin
                        ackOut0_q <= 1'b0;
                        ackOut1_q <= 1'b0;
                        if (gnt_q) cnt1_q <= cnt1_q + CntOne;
                        else       cnt0_q <= cnt0_q + CntOne;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    sendOut_q <= 1'b0;
                    ackOut0_q <= 1'b0;
                    ackOut1_q <= 1'b0;
                end
            endcase
        end
    end

    assign Send_out = sendOut_q;
    assign Ack_out0 = ackOut0_q;
    assign Ack_out1 = ackOut1_q;
    assign Data_out = dataOut_q;
    assign Gnt      = gnt_q;
    assign Busy     = (state_q != IDLE);
    assign Cnt0     = cnt0_q;
    assign Cnt1     = cnt1_q;

endmodule

// File: tb/tb_cf_merge_arbiter.sv
// Scoreboard bench for cf_merge_arbiter: upstream producers, a downstream responder and
// a queue of expected grants in the order the round-robin model predicts.
module tb_cf_merge_arbiter;

    localparam int DW = 32;
    localparam int CW = 2;

    logic          CLK = 1'b0;
    logic          MR_n = 1'b1;
    logic [1:0]    sendIn = '0;
    logic [DW-1:0] dataIn [2];
    logic          respAck = 1'b0;
    logic          spurAck = 1'b0;
    logic          Ack_in;
    logic          Ack_out0;
    logic          Ack_out1;
    logic          Send_out;
    logic [DW-1:0] Data_out;
    logic          Gnt;
    logic          Busy;
    logic [CW-1:0] Cnt0;
    logic [CW-1:0] Cnt1;
    logic [1:0]    ackOut;

    typedef struct {
        logic          idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t expQ[$];
    int   compared = 0;
    int   mismatched = 0;
    int   modelCnt[2];
    logic modelGnt;
    int   pktDone = 0;
    int   respDelay = 2;

    assign Ack_in = respAck | spurAck;
    assign ackOut = {Ack_out1, Ack_out0};

    always #5 CLK = ~CLK;

    cf_merge_arbiter #(.DW(DW), .CW(CW)) dut (
        .CLK      (CLK),
        .MR_n     (MR_n),
        .Send_in0 (sendIn[0]),
        .Send_in1 (sendIn[1]),
        .Data_in0 (dataIn[0]),
        .Data_in1 (dataIn[1]),
        .Ack_out0 (Ack_out0),
        .Ack_out1 (Ack_out1),
        .Send_out (Send_out),
        .Data_out (Data_out),
        .Ack_in   (Ack_in),
        .Gnt      (Gnt),
        .Busy     (Busy),
        .Cnt0     (Cnt0),
        .Cnt1     (Cnt1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        if (obs !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic pushExp(input logic idx, input logic [DW-1:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Reset is dropped between clock edges so the outputs must clear without a clock.
    task automatic applyReset();
        #2;
        MR_n = 1'b0;
        #1;
        checkOutput("rstSendOut", 64'(Send_out), 64'd0);
        checkOutput("rstBusy",    64'(Busy),     64'd0);
        checkOutput("rstDataOut", 64'(Data_out), 64'd0);
        checkOutput("rstGnt",     64'(Gnt),      64'd1);
        checkOutput("rstAck",     64'(ackOut),   64'd0);
        checkOutput("rstCnt0",    64'(Cnt0),     64'd0);
        checkOutput("rstCnt1",    64'(Cnt1),     64'd0);
        modelCnt[0] = 0;
        modelCnt[1] = 0;
        modelGnt    = 1'b1;
        repeat (3) @(negedge CLK);
        MR_n = 1'b1;
    endtask

    task automatic applyStimulus(input int idx, input logic [DW-1:0] data, input bit measure);
        int n;
        @(negedge CLK);
        dataIn[idx] = data;
        sendIn[idx] = 1'b1;
        if (measure) begin
            n = 0;
            do begin
                @(posedge CLK);
                #1;
                n++;
            end while (Send_out !== 1'b1 && n < 10);
            checkOutput("latency", 64'(n), 64'd3);
        end
        n = 0;
        while (ackOut[idx] !== 1'b1 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 500) begin
            checkOutput("ackRiseTimeout", 64'd1, 64'd0);
            sendIn[idx] = 1'b0;
            pktDone++;
            return;
        end
        sendIn[idx] = 1'b0;
        n = 0;
        while (ackOut[idx] !== 1'b0 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 500) checkOutput("ackFallTimeout", 64'd1, 64'd0);
        modelCnt[idx] = (modelCnt[idx] + 1) % (1 << CW);
        checkOutput(idx != 0 ? "cnt1" : "cnt0", 64'(idx != 0 ? Cnt1 : Cnt0), 64'(modelCnt[idx]));
        pktDone++;
    endtask

    task automatic waitDone(input int target);
        int n;
        n = 0;
        while (pktDone < target && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 3000) checkOutput("doneTimeout", 64'(pktDone), 64'(target));
    endtask

    always @(negedge CLK) begin
        checkOutput("ackExclusive", 64'(Ack_out0 & Ack_out1), 64'd0);
    end

    // Downstream side: every Send_out rise is matched against the head of the queue.
    initial begin
        exp_t e;
        bit   aborted;
        int   n;
        forever begin
            @(negedge CLK);
            if (Send_out === 1'b1) begin
                aborted = 1'b0;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedGrant", 64'd1, 64'd0);
                    e.idx  = Gnt;
                    e.data = Data_out;
                end else begin
                    e = expQ.pop_front();
                end
                checkOutput("gnt",     64'(Gnt),      64'(e.idx));
                checkOutput("dataOut", 64'(Data_out), 64'(e.data));
                for (int d = 0; d < respDelay; d++) begin
                    @(negedge CLK);
                    if (Send_out !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    checkOutput("dataHold", 64'(Data_out), 64'(e.data));
                end
                if (!aborted) begin
                    respAck = 1'b1;
                    n = 0;
                    while (Send_out === 1'b1 && n < 200) begin
                        @(negedge CLK);
                        n++;
                    end
                    if (n >= 200) checkOutput("sendOutDropTimeout", 64'd1, 64'd0);
                    checkOutput("ackOutGnt",   64'(ackOut[e.idx]),  64'd1);
                    checkOutput("ackOutOther", 64'(ackOut[~e.idx]), 64'd0);
                    @(negedge CLK);
                    respAck = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] a [3];
        logic [DW-1:0] b [3];
        logic [DW-1:0] d;
        logic          winner;
        int            n;
        dataIn[0] = '0;
        dataIn[1] = '0;
        applyReset();

        $display("[TB] single request with latency check");
        pushExp(1'b0, 32'hA5A5_A5A5);
        applyStimulus(0, 32'hA5A5_A5A5, 1'b1);

        $display("[TB] simultaneous tie after reset");
        applyReset();
        a[0] = $urandom;
        b[0] = $urandom;
        winner = ~modelGnt;
        pushExp(winner,  winner ? b[0] : a[0]);
        pushExp(~winner, winner ? a[0] : b[0]);
        modelGnt = ~winner;
        fork
            applyStimulus(0, a[0], 1'b0);
            applyStimulus(1, b[0], 1'b0);
        join

        $display("[TB] continuous contention");
        for (int i = 0; i < 3; i++) begin
            a[i] = $urandom;
            b[i] = $urandom;
        end
        for (int i = 0; i < 6; i++) begin
            winner = ~modelGnt;
            pushExp(winner, winner ? b[i/2] : a[i/2]);
            modelGnt = winner;
        end
        fork
            begin
                for (int i = 0; i < 3; i++) applyStimulus(0, a[i], 1'b0);
            end
            begin
                for (int i = 0; i < 3; i++) applyStimulus(1, b[i], 1'b0);
            end
        join

        $display("[TB] counter wrap on requester 1");
        applyReset();
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            pushExp(1'b1, d);
            applyStimulus(1, d, 1'b0);
        end

        $display("[TB] reset during REQ");
        applyReset();
        respDelay = 20;
        d = $urandom;
        pushExp(1'b1, d);
        pktDone = 0;
        fork
            applyStimulus(1, d, 1'b0);
        join_none
        n = 0;
        while (Send_out !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) checkOutput("reqWaitTimeout", 64'd1, 64'd0);
        @(negedge CLK);
        pushExp(1'b1, d);
        applyReset();
        waitDone(1);
        respDelay = 2;

        $display("[TB] spurious Ack_in while idle");
        repeat (3) @(negedge CLK);
        spurAck = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            checkOutput("spurBusy", 64'(Busy), 64'd0);
        end
        spurAck = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            checkOutput("spurBusy", 64'(Busy),   64'd0);
            checkOutput("spurAck",  64'(ackOut), 64'd0);
        end
        checkOutput("spurCnt0", 64'(Cnt0), 64'(modelCnt[0]));
        checkOutput("spurCnt1", 64'(Cnt1), 64'(modelCnt[1]));

        repeat (5) @(negedge CLK);
        checkOutput("queueLeft", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
